// File: rtl/snd_pkg.sv
// Shared types, note table and half-period helper for the note synthesizer.
package snd_pkg;

  typedef enum logic [1:0] {
    ST_SILENT = 2'd0,
    ST_GAP    = 2'd1,
    ST_TONE   = 2'd2
  } state_e;

  localparam logic [3:0] NOTE_REST = 4'd0;

  // Tone frequencies in Hz; index 0 is note code 1 (C4), index 14 is note code 15 (C6).
  localparam logic [14:0][10:0] FREQ_HZ = {
    11'd1047, 11'd988, 11'd880, 11'd784, 11'd698, 11'd659, 11'd587, 11'd523,
    11'd494,  11'd440, 11'd392, 11'd349, 11'd330, 11'd294, 11'd262
  };

  // Clocks per half period of a note; the rest code has no period.
  function automatic int unsigned half_period(input logic [3:0] note, input int unsigned clk_hz);
    int unsigned f;
    int unsigned res;
    res = 0;
    if (note != NOTE_REST) begin
      f   = 32'(FREQ_HZ[note - 4'd1]);
      res = clk_hz / (2 * f);
    end
    return res;
  endfunction

endpackage

// File: rtl/note_env.sv
// Volume envelope: a level that decays in steps down to a floor, plus the
// 3-bit PWM counter that gates the square wave against that level.
module note_env
  import snd_pkg::*;
#(
  parameter int unsigned DECAY_CYCLES = 5_000_000,
  parameter int unsigned MIN_LEVEL    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic gate
);

  localparam int unsigned      DW         = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam logic [DW-1:0]    DECAY_LAST = DW'(DECAY_CYCLES - 1);
  localparam logic [2:0]       FLOOR      = 3'(MIN_LEVEL);

  logic [2:0]    level_q, level_d;
  logic [2:0]    pwm_q, pwm_d;
  logic [DW-1:0] decay_q, decay_d;

  // start re-arms a fresh note at full level; run advances PWM and decay while the tone plays.
  always_comb begin
    level_d = level_q;
    pwm_d   = pwm_q;
    decay_d = decay_q;
    if (start) begin
      level_d = 3'd7;
      pwm_d   = 3'd0;
      decay_d = '0;
    end else if (run) begin
      pwm_d = pwm_q + 3'd1;
      if (decay_q == DECAY_LAST) begin
        decay_d = '0;
        if (level_q > FLOOR) level_d = level_q - 3'd1;
      end else begin
        decay_d = decay_q + DW'(1);
      end
    end
  end

  // Envelope state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 3'd0;
      pwm_q   <= 3'd0;
      decay_q <= '0;
    end else begin
      level_q <= level_d;
      pwm_q   <= pwm_d;
      decay_q <= decay_d;
    end
  end

  // Duty cycle is level/8; level 0 keeps the gate shut.
  assign gate = (pwm_q < level_q);

endmodule

// File: rtl/note_synth.sv
// Note-code synthesizer: articulation gap, square-wave tone generator with
// decaying PWM envelope, and registered mute on the buzzer output.
module note_synth
  import snd_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned GAP_CYCLES   = 2_500_000,
  parameter int unsigned DECAY_CYCLES = 5_000_000,
  parameter int unsigned MIN_LEVEL    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] note,
  input  logic       mute,
  output logic       wave,
  output logic       playing
);

  // C4 has the longest half period, so it sets the counter width.
  localparam int unsigned   HW       = $clog2(half_period(4'd1, CLK_HZ) + 1);
  localparam int unsigned   GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  // Reload values (HALF-1) per note code, all elaboration-time constants.
  logic [15:0][HW-1:0] half_tbl;
  for (genvar g = 0; g < 16; g++) begin : g_half
    if (g == 0) begin : g_rest
      assign half_tbl[g] = '0;
    end else begin : g_note
      assign half_tbl[g] = HW'(half_period(4'(g), CLK_HZ) - 32'd1);
    end
  end

  state_e        state_q, state_d;
  logic [3:0]    note_q, note_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [HW-1:0] half_q, half_d;
  logic          phase_q, phase_d;
  logic          wave_q, playing_q;
  logic          env_start, env_run, env_gate;

  // Sequencing: a note change always wins over gap expiry, so the gap restarts.
  always_comb begin
    state_d   = state_q;
    note_d    = note_q;
    gap_d     = gap_q;
    half_d    = half_q;
    phase_d   = phase_q;
    env_start = 1'b0;
    case (state_q)
      ST_SILENT: begin
        if (note != NOTE_REST) begin
          note_d  = note;
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (note == NOTE_REST) begin
          state_d = ST_SILENT;
        end else if (note != note_q) begin
          note_d = note;
          gap_d  = GAP_LOAD;
        end else if (gap_q == '0) begin
          state_d   = ST_TONE;
          half_d    = half_tbl[note_q];
          phase_d   = 1'b1;
          env_start = 1'b1;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      ST_TONE: begin
        if (half_q == '0) begin
          half_d  = half_tbl[note_q];
          phase_d = ~phase_q;
        end else begin
          half_d = half_q - HW'(1);
        end
        if (note == NOTE_REST) begin
          state_d = ST_SILENT;
        end else if (note != note_q) begin
          note_d  = note;
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end
      end
      default: state_d = ST_SILENT;
    endcase
  end

  assign env_run = (state_q == ST_TONE);

  note_env #(
    .DECAY_CYCLES(DECAY_CYCLES),
    .MIN_LEVEL   (MIN_LEVEL)
  ) u_env (
    .clk  (clk),
    .rst_n(rst_n),
    .start(env_start),
    .run  (env_run),
    .gate (env_gate)
  );

  // Sequencer and tone-generator state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SILENT;
      note_q  <= NOTE_REST;
      gap_q   <= '0;
      half_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      gap_q   <= gap_d;
      half_q  <= half_d;
      phase_q <= phase_d;
    end
  end

  // Output registers; mute only masks the pin, the tone keeps advancing underneath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_q    <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      wave_q    <= (state_q == ST_TONE) & phase_q & env_gate & ~mute;
      playing_q <= (state_q == ST_TONE);
    end
  end

  assign wave    = wave_q;
  assign playing = playing_q;

endmodule
